// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory access unit:
//   - default address/data widths
//   - wait counter width (WAIT_STATES is limited to 0..15)
//   - FSM state encodings IDLE / ACCESS / DONE
// Optional feature macro used by the design: MEM_PARITY_EN
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

endpackage

// File: rtl/memory_access_unit_if.sv
// -----------------------------------------------------------------------------
// memory_access_unit_if
// Request/response bundle between the MAR/MDR side (master) and the memory
// access unit (slave).
//   read, write  : request strobes (sampled by the unit only when it can accept)
//   addr         : word address (from MAR)
//   wdata        : write data (from MDR Q)
//   rdata        : read data (to MDR D1), holds the last read result
//   busy         : unit is not idle
//   done         : one-cycle completion pulse
//   err          : parity error, valid with done (only with MEM_PARITY_EN)
// -----------------------------------------------------------------------------
interface memory_access_unit_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output read, write, addr, wdata,
        input  rdata, busy, done, err
    );

    modport slave (
        input  read, write, addr, wdata,
        output rdata, busy, done, err
    );
endinterface

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Synchronous single-port RAM, 2**ADDR_W words of WIDTH bits.
//   clk    : clock
//   rst    : asynchronous active-high reset of the read register only
//   we     : write enable, mem[addr] <= wdata
//   re     : read enable, rdata register <= mem[addr]
//   addr   : word address
//   wdata  : write word
//   rdata  : registered read word; holds its value when re is low
// Array contents are never reset.
// -----------------------------------------------------------------------------
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WIDTH  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/memory_access_unit.sv
// -----------------------------------------------------------------------------
// memory_access_unit
// Word-addressed RAM plus access sequencer between MAR/MDR and main memory.
// Single read/write requests are latched, held for WAIT_STATES extra cycles,
// then applied to the array; completion is signalled by a one-cycle done.
//   clk  : system clock, rising edge
//   clr  : asynchronous active-high reset (aborts any access in flight)
//   bus  : memory_access_unit_if.slave (read, write, addr, wdata, rdata,
//          busy, done, err)
// Parameters: ADDR_W, DATA_W, WAIT_STATES (0..15)
// Optional feature: MEM_PARITY_EN -- stores an even-parity bit per word and
// flags err during DONE when a read finds a mismatch. Without it the array is
// DATA_W bits wide and err is constant 0.
// -----------------------------------------------------------------------------
module memory_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    memory_access_unit_if.slave  bus
);

`ifdef MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              mem_we;
    logic              mem_re;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  mem_rdata;

    // DONE also samples the next request, so back-to-back accesses cost
    // WAIT_STATES+2 cycles: the completion cycle doubles as the next accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.read || bus.write) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_re  = op_rd_q;
                    mem_we  = ~op_rd_q;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // read wins when both strobes are high; the write is dropped
            if (accept) begin
                op_rd_q <= bus.read;
            end
        end
    end

    // Request latches: only meaningful after an accept, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

`ifdef MEM_PARITY_EN
    assign mem_wdata = {^wdata_q, wdata_q};
`else
    assign mem_wdata = wdata_q;
`endif

    // The array's read register is rdata itself: it only loads on a read
    // completion and is cleared by clr.
    mem_array #(
        .ADDR_W (ADDR_W),
        .WIDTH  (MEM_W)
    ) u_mem (
        .clk   (clk),
        .rst   (clr),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign bus.rdata = mem_rdata[DATA_W-1:0];
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);

`ifdef MEM_PARITY_EN
    // Word plus stored even-parity bit must XOR to 0 on a clean read.
    assign bus.err = bus.done && op_rd_q && (^mem_rdata);
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_access_unit
// Two units share clk/clr: dut1 with WAIT_STATES=1 and dut0 with
// WAIT_STATES=0. Expected responses come from a word-array model and are
// queued at request time; per-unit monitors pop them on every done pulse.
// -----------------------------------------------------------------------------
module tb_memory_access_unit;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int WS1 = 1;
    localparam int WS0 = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    memory_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    memory_access_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS1)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (bus1)
    );

    memory_access_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS0)) dut0 (
        .clk (clk),
        .clr (clr),
        .bus (bus0)
    );

    // Reference model: one word array and last-read register per unit.
    logic [31:0] ref_mem [2][512];
    logic [31:0] last_rd [2];
    exp_t        q0 [$];
    exp_t        q1 [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic busy_of(input int d);
        return (d == 1) ? bus1.busy : bus0.busy;
    endfunction

    function automatic logic done_of(input int d);
        return (d == 1) ? bus1.done : bus0.done;
    endfunction

    task automatic drive(input int d, input bit rd, input bit wr,
                         input logic [8:0] a, input logic [31:0] w);
        if (d == 1) begin
            bus1.read = rd; bus1.write = wr; bus1.addr = a; bus1.wdata = w;
        end else begin
            bus0.read = rd; bus0.write = wr; bus0.addr = a; bus0.wdata = w;
        end
    endtask

    // One request: wait for idle, raise it for a single edge, then scramble the
    // inputs. With spur set, a conflicting write is held up while busy.
    task automatic issue(input int d, input bit rd, input bit wr, input logic [8:0] a,
                         input logic [31:0] w, input bit spur, input bit perr);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy_of(d) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 1, 0);
        drive(d, rd, wr, a, w);
        e.due = cyc + 2 + ((d == 1) ? WS1 : WS0);
        if (rd) begin
            e.data     = ref_mem[d][a];
            last_rd[d] = e.data;
        end else begin
            ref_mem[d][a] = w;
            e.data        = last_rd[d];
        end
        e.err = perr;
        if (d == 1) q1.push_back(e); else q0.push_back(e);
        @(negedge clk);
        if (spur) begin
            drive(d, 1'b0, 1'b1, a, ~w);
            n = 0;
            while (!done_of(d) && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        drive(d, 1'b0, 1'b0, 9'($urandom), $urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() != 0 || bus0.busy || bus1.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 1, 0);
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!clr && bus1.done) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("dut1_done_cycle", cyc, e.due);
                chk("dut1_rdata", bus1.rdata, e.data);
                chk("dut1_err", {31'd0, bus1.err}, {31'd0, e.err});
            end
        end
    end

    always @(negedge clk) begin : mon0
        exp_t e;
        if (!clr && bus0.done) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_done", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("dut0_done_cycle", cyc, e.due);
                chk("dut0_rdata", bus0.rdata, e.data);
                chk("dut0_err", {31'd0, bus0.err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t        e;
        logic [8:0]  pool [8];
        logic [8:0]  a;
        int          op;

        clr = 1'b1;
        drive(1, 0, 0, '0, '0);
        drive(0, 0, 0, '0, '0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy1", {31'd0, bus1.busy}, 0);
        chk("rst_done1", {31'd0, bus1.done}, 0);
        chk("rst_rdata1", bus1.rdata, 0);
        chk("rst_err1", {31'd0, bus1.err}, 0);
        chk("rst_busy0", {31'd0, bus0.busy}, 0);
        chk("rst_rdata0", bus0.rdata, 0);
        clr = 1'b0;

        // Write then read back with one wait state.
        issue(1, 0, 1, 9'h005, 32'hDEADBEEF, 0, 0);
        issue(1, 1, 0, 9'h005, 32'h0, 0, 0);

        // read and write together: read wins, memory untouched.
        issue(1, 0, 1, 9'h010, 32'h12345678, 0, 0);
        issue(1, 1, 1, 9'h010, 32'hCAFEF00D, 0, 0);
        issue(1, 1, 0, 9'h010, 32'h0, 0, 0);

        // A write raised while busy must be ignored.
        issue(1, 0, 1, 9'h033, 32'h0BADF00D, 1, 0);
        issue(1, 1, 0, 9'h033, 32'h0, 0, 0);

        // clr in the middle of a write: outputs clear at once, write is lost.
        issue(1, 0, 1, 9'h030, 32'hA5A5A5A5, 0, 0);
        drain();
        @(negedge clk);
        drive(1, 0, 1, 9'h030, 32'h5A5A5A5A);
        @(negedge clk);
        clr = 1'b1;
        drive(1, 0, 0, '0, '0);
        #1;
        chk("clr_busy", {31'd0, bus1.busy}, 0);
        chk("clr_done", {31'd0, bus1.done}, 0);
        chk("clr_rdata", bus1.rdata, 0);
        @(negedge clk);
        clr = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        issue(1, 1, 0, 9'h030, 32'h0, 0, 0);

        // Zero wait states: back-to-back reads of the bottom and top words.
        issue(0, 0, 1, 9'h000, 32'h11112222, 0, 0);
        issue(0, 0, 1, 9'h1FF, 32'h33334444, 0, 0);
        drain();
        @(negedge clk);
        drive(0, 1, 0, 9'h000, '0);
        e.due = cyc + 2;
        e.data = ref_mem[0][9'h000];
        e.err = 1'b0;
        q0.push_back(e);
        @(negedge clk);
        bus0.addr = 9'h1FF;
        @(negedge clk);
        e.due = cyc + 2;
        e.data = ref_mem[0][9'h1FF];
        q0.push_back(e);
        last_rd[0] = e.data;
        @(negedge clk);
        drive(0, 0, 0, '0, '0);
        drain();

`ifdef MEM_PARITY_EN
        issue(1, 0, 1, 9'h020, 32'h0F0F0001, 0, 0);
        drain();
        dut1.u_mem.mem[9'h020][3] = ~dut1.u_mem.mem[9'h020][3];
        ref_mem[1][9'h020][3] = ~ref_mem[1][9'h020][3];
        issue(1, 1, 0, 9'h020, 32'h0, 0, 1);
        issue(1, 0, 1, 9'h020, 32'h76543210, 0, 0);
        issue(1, 1, 0, 9'h020, 32'h0, 0, 0);
`endif

        // Randomised traffic over a pool of written addresses.
        pool = '{9'h000, 9'h1FF, 9'h005, 9'h010, 9'h033, 9'h030, 9'h0FF, 9'h100};
        issue(1, 0, 1, 9'h000, $urandom, 0, 0);
        issue(1, 0, 1, 9'h1FF, $urandom, 0, 0);
        issue(1, 0, 1, 9'h0FF, $urandom, 0, 0);
        issue(1, 0, 1, 9'h100, $urandom, 0, 0);
        for (int i = 0; i < 40; i++) begin
            a  = pool[$urandom_range(0, 7)];
            op = $urandom_range(0, 2);
            issue(1, op != 0, op != 1, a, $urandom, $urandom_range(0, 3) == 0, 0);
        end

        drain();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
